// File: rtl/bmu_bitcnt_pkg.sv
// rtl/bmu_bitcnt_pkg.sv - shared types and sizing for the sequential bit-count unit
package bmu_bitcnt_pkg;

  localparam int BC_WIDTH = 64;
  localparam int BC_CHUNK = 16;
  localparam int NCHUNK   = BC_WIDTH / BC_CHUNK;
  localparam int CIDX_W   = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    BC_CPOP = 2'b00,
    BC_CLZ  = 2'b01,
    BC_CTZ  = 2'b10,
    BC_RSVD = 2'b11
  } bc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bc_state_e;

endpackage

// File: rtl/bitcnt_chunk.sv
// rtl/bitcnt_chunk.sv - combinational popcount / leading-zero count of one CHUNK-bit slice
module bitcnt_chunk #(
  parameter int CHUNK = 16,
  parameter int CW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] i_chunk,
  output logic [CW-1:0]    o_pop,
  output logic [CW-1:0]    o_lz,
  output logic             o_nonzero
);

  // Scan upward so the highest set bit is the last one to write o_lz.
  always_comb begin
    o_pop = '0;
    o_lz  = CW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      o_pop = o_pop + CW'(i_chunk[i]);
      if (i_chunk[i]) o_lz = CW'(CHUNK - 1 - i);
    end
  end

  assign o_nonzero = |i_chunk;

endmodule

// File: rtl/bmu_bitcnt_seq.sv
// rtl/bmu_bitcnt_seq.sv - multi-cycle cpop/clz/ctz, one CHUNK slice per cycle
// BITCNT_EARLY_EXIT_EN: clz/ctz leave RUN on the first nonzero chunk.
module bmu_bitcnt_seq
  import bmu_bitcnt_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int CHUNK = BC_CHUNK
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       Start,
  output logic                       Ready,
  input  logic                       Flush,
  input  logic [1:0]                 Op,
  input  logic                       W,
  input  logic [WIDTH-1:0]           A,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(WIDTH):0]     Result
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = $clog2(NCH + 1);
  localparam int RW  = $clog2(WIDTH) + 1;
  localparam int CW  = $clog2(CHUNK) + 1;

  bc_state_e        r_state;
  logic [WIDTH-1:0] r_opnd;
  logic [RW-1:0]    r_acc;
  logic [RW-1:0]    r_result;
  logic             r_found;
  logic             r_is_lz;
  logic [IW-1:0]    r_cidx;
  logic [IW-1:0]    r_last;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_ctz_src;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_wsel;
  logic [WIDTH-1:0] w_capt;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_lz;
  logic             w_nz;
  logic [RW-1:0]    w_add;
  logic [RW-1:0]    w_acc_nxt;
  logic             w_last;
  logic             w_exit;

  // W=1 left-justifies the low word; ctz reverses within the effective width,
  // which for W=1 lands the reversed low word in the top half as well.
  assign w_ctz_src = W ? (A & WIDTH'(32'hFFFF_FFFF)) : A;
  assign w_wsel    = W ? (A << (WIDTH - 32)) : A;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign w_rev[WIDTH-1-gi] = w_ctz_src[gi];
  end

  assign w_capt = (bc_op_e'(Op) == BC_CTZ) ? w_rev : w_wsel;

  bitcnt_chunk #(.CHUNK(CHUNK), .CW(CW)) u_chunk (
    .i_chunk   (r_opnd[WIDTH-1 -: CHUNK]),
    .o_pop     (w_pop),
    .o_lz      (w_lz),
    .o_nonzero (w_nz)
  );

  assign w_add     = r_is_lz ? (r_found ? '0 : RW'(w_lz)) : RW'(w_pop);
  assign w_acc_nxt = r_acc + w_add;
  assign w_last    = (r_cidx == r_last);

`ifdef BITCNT_EARLY_EXIT_EN
  assign w_exit = w_last | (r_is_lz & ~r_found & w_nz);
`else
  assign w_exit = w_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_found  <= 1'b0;
      r_is_lz  <= 1'b0;
      r_cidx   <= '0;
      r_last   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (Start && !Flush) begin
            r_opnd  <= w_capt;
            r_acc   <= '0;
            r_found <= 1'b0;
            r_cidx  <= '0;
            r_last  <= W ? IW'(32 / CHUNK - 1) : IW'(NCH - 1);
            r_is_lz <= (bc_op_e'(Op) == BC_CLZ) || (bc_op_e'(Op) == BC_CTZ);
            r_state <= RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (Flush) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_acc   <= w_acc_nxt;
            r_found <= r_found | w_nz;
            r_opnd  <= r_opnd << CHUNK;
            r_cidx  <= r_cidx + IW'(1);
            if (w_exit) begin
              r_result <= w_acc_nxt;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Ready  = r_ready;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_bmu_bitcnt_seq.sv
// tb/tb_bmu_bitcnt_seq.sv - directed vector bench for bmu_bitcnt_seq
module tb_bmu_bitcnt_seq;

`ifdef BITCNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic        W = 1'b0;
  logic [63:0] A = '0;
  logic        Ready, Busy, Done;
  logic [6:0]  Result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bmu_bitcnt_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .Ready   (Ready),
    .Flush   (Flush),
    .Op      (Op),
    .W       (W),
    .A       (A),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [6:0]  res;
    int          lat_fix;
    int          lat_ee;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start is driven mid-cycle t; lat counts cycles from t to the Done cycle.
  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        output int lat, output logic [6:0] res);
    @(negedge clk);
    Op = op; W = w; A = a; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = Result;
  endtask

  initial begin
    int          lat;
    logic [6:0]  res;
    logic [6:0]  prev;
    bit          seen;

    vecs[0]  = '{"cpop_ones",    2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 5, 5};
    vecs[1]  = '{"clz_bit16",    2'b01, 1'b0, 64'h0000_0000_0001_0000, 7'd47, 5, 4};
    vecs[2]  = '{"ctz_msb",      2'b10, 1'b0, 64'h8000_0000_0000_0000, 7'd63, 5, 5};
    vecs[3]  = '{"cpop_w",       2'b00, 1'b1, 64'hFFFF_FFFF_0000_00F0, 7'd4,  3, 3};
    vecs[4]  = '{"clz_zero",     2'b01, 1'b0, 64'h0,                   7'd64, 5, 5};
    vecs[5]  = '{"clz_w_zero",   2'b01, 1'b1, 64'hFFFF_FFFF_0000_0000, 7'd32, 3, 3};
    vecs[6]  = '{"ctz_w_one",    2'b10, 1'b1, 64'h1,                   7'd0,  3, 2};
    vecs[7]  = '{"rsvd_cpop",    2'b11, 1'b0, 64'h0F0F_0000_0000_0001, 7'd9,  5, 5};
    vecs[8]  = '{"ctz_bit8",     2'b10, 1'b0, 64'h0000_0000_0000_0100, 7'd8,  5, 2};
    vecs[9]  = '{"clz_msb",      2'b01, 1'b0, 64'h8000_0000_0000_0000, 7'd0,  5, 2};
    vecs[10] = '{"cpop_w_zero",  2'b00, 1'b1, 64'hFFFF_FFFF_0000_0000, 7'd0,  3, 3};
    vecs[11] = '{"clz_lsb",      2'b01, 1'b0, 64'h1,                   7'd63, 5, 5};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",  Ready,  1);
    chk("rst_busy",   Busy,   0);
    chk("rst_done",   Done,   0);
    chk("rst_result", Result, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Ready drops and Busy rises the cycle after Start
    @(negedge clk);
    Op = 2'b00; W = 1'b0; A = 64'hF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("start_ready_low", Ready, 0);
    chk("start_busy_high", Busy, 1);
    lat = 1;
    while (!Done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("start_lat", lat, 5);
    chk("start_res", Result, 4);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, lat, res);
      chk({vecs[i].name, "_res"}, res, vecs[i].res);
      chk({vecs[i].name, "_lat"}, lat, EE ? vecs[i].lat_ee : vecs[i].lat_fix);
      @(negedge clk);
      chk({vecs[i].name, "_pulse"}, {Done, Ready}, 2'b01);
      chk({vecs[i].name, "_hold"}, Result, vecs[i].res);
    end

    // Flush mid-RUN with an ignored Start while busy
    prev = Result;
    @(negedge clk);
    Op = 2'b00; W = 1'b0; A = 64'hFFFF_FFFF_FFFF_FFFF; Start = 1'b1;
    @(negedge clk);
    Op = 2'b01; A = 64'h0;
    seen = Done;
    chk("flush_t1_busy", Busy, 1);
    @(negedge clk);
    Start = 1'b0; Flush = 1'b1;
    seen = seen | Done;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush_ready", Ready, 1);
    chk("flush_busy", Busy, 0);
    chk("flush_result", Result, prev);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | Done;
    end
    chk("flush_no_done", seen, 0);

    // Start together with Flush in IDLE is not accepted
    Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    chk("start_flush_ready", Ready, 1);
    chk("start_flush_busy", Busy, 0);

    // asynchronous reset during RUN, checked before any clock edge
    Op = 2'b00; W = 1'b0; A = 64'hFF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", Busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready",  Ready,  1);
    chk("arst_busy",   Busy,   0);
    chk("arst_done",   Done,   0);
    chk("arst_result", Result, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // operation after reset release
    run_op(2'b00, 1'b0, 64'hFF00, lat, res);
    chk("post_rst_res", res, 8);
    chk("post_rst_lat", lat, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
